register_writeback_queue: RTL and testbench

Buffers register-file write requests from the two result producers (ALU and memory/receive unit) and drains them, one per cycle, into the general purpose register file's write port (address_3 / general_register_write_data / general_register_write_enable). It sits directly upstream of the register file write port. It tracks which registers have writes still queued so decode can stall on read-after-write hazards. When the register file write port is claimed elsewhere, `write_stall` holds the queue.

---
 rtl/register_writeback_queue.sv | 73 +++++++
 tb/tb_register_writeback_queue.sv | 133 +++++++++++++
 2 files changed

// File: rtl/register_writeback_queue.sv
// register_writeback_queue: FIFO of ALU/memory register writes that drains one entry per cycle into the register file and flags registers with pending writes.
module register_writeback_queue #(
  parameter int ADDRESS_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_valid,
  input  logic [ADDRESS_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic mem_ready,
  input  logic alu_valid,
  input  logic [ADDRESS_WIDTH-1:0] alu_address,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic alu_ready,
  input  logic write_stall,
  output logic general_register_write_enable,
  output logic [ADDRESS_WIDTH-1:0] address_3,
  output logic [DATA_WIDTH-1:0] general_register_write_data,
  output logic [2**ADDRESS_WIDTH-1:0] pending,
  output logic full,
  output logic empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NR = 2**ADDRESS_WIDTH;
  logic [ADDRESS_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] cnt_q [NR];
  logic [ADDRESS_WIDTH-1:0] in_addr, head_addr;
  logic [DATA_WIDTH-1:0] in_data;
  logic push, pop;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign in_addr = mem_valid ? mem_address : alu_address;
  assign in_data = mem_valid ? mem_data : alu_data;
  // r0 writes complete the handshake but are never stored
  assign push = (mem_valid || alu_valid) && !full && in_addr != '0;
  assign pop = !empty && !write_stall;
  assign head_addr = addr_q[rd_q];
  assign general_register_write_enable = pop;
  assign address_3 = empty ? '0 : head_addr;
  assign general_register_write_data = empty ? '0 : data_q[rd_q];
  assign count_d = count_q + CW'(push) - CW'(pop);
  assign pending[0] = 1'b0;
  for (genvar r = 1; r < NR; r++) begin : g_pend
    assign pending[r] = cnt_q[r] != '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      for (int i = 0; i < NR; i++) cnt_q[i] <= '0;
    end else begin
      if (push) begin
        addr_q[wr_q] <= in_addr;
        data_q[wr_q] <= in_data;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      count_q <= count_d;
      for (int i = 0; i < NR; i++)
        cnt_q[i] <= cnt_q[i] + CW'(push && in_addr == ADDRESS_WIDTH'(i))
                             - CW'(pop && head_addr == ADDRESS_WIDTH'(i));
    end
  end
endmodule

// File: tb/tb_register_writeback_queue.sv
// tb_register_writeback_queue: directed vector table plus randomized traffic checked against a queue-based model.
module tb_register_writeback_queue;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset, mem_valid, alu_valid, write_stall;
  logic [1:0] mem_address, alu_address, address_3;
  logic [7:0] mem_data, alu_data, general_register_write_data;
  logic mem_ready, alu_ready, general_register_write_enable, full, empty;
  logic [3:0] pending;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  register_writeback_queue dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_address(mem_address), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_address(alu_address), .alu_data(alu_data), .alu_ready(alu_ready),
    .write_stall(write_stall),
    .general_register_write_enable(general_register_write_enable),
    .address_3(address_3), .general_register_write_data(general_register_write_data),
    .pending(pending), .full(full), .empty(empty)
  );
  typedef struct packed {
    logic rs, mv; logic [1:0] ma; logic [7:0] md;
    logic av; logic [1:0] aa; logic [7:0] ad; logic ws;
    logic [18:0] exp;
  } vec_t;
  typedef struct packed { logic [1:0] a; logic [7:0] d; } ent_t;
  vec_t vecs[$];
  ent_t model[$];
  function automatic logic [18:0] e(logic we, logic [1:0] a, logic [7:0] d, logic [3:0] p,
                                    logic f, logic em, logic mr, logic ar);
    return {we, a, d, p, f, em, mr, ar};
  endfunction
  function automatic logic [18:0] actual();
    return {general_register_write_enable, address_3, general_register_write_data, pending,
            full, empty, mem_ready, alu_ready};
  endfunction
  task automatic add(input logic rs, input logic mv, input logic [1:0] ma, input logic [7:0] md,
                     input logic av, input logic [1:0] aa, input logic [7:0] ad, input logic ws,
                     input logic [18:0] x);
    vecs.push_back({rs, mv, ma, md, av, aa, ad, ws, x});
  endtask
  task automatic check(input string name, input logic [18:0] x);
    logic [18:0] a;
    a = actual();
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got we/addr/data/pend/full/empty/mr/ar=%b/%h/%h/%b/%b/%b/%b/%b want %b/%h/%h/%b/%b/%b/%b/%b",
               name, a[18], a[17:16], a[15:8], a[7:4], a[3], a[2], a[1], a[0],
               x[18], x[17:16], x[15:8], x[7:4], x[3], x[2], x[1], x[0]);
    end
  endtask
  task automatic drive(input logic rs, input logic mv, input logic [1:0] ma, input logic [7:0] md,
                       input logic av, input logic [1:0] aa, input logic [7:0] ad, input logic ws);
    reset = rs; mem_valid = mv; mem_address = ma; mem_data = md;
    alu_valid = av; alu_address = aa; alu_data = ad; write_stall = ws;
  endtask
  initial begin
    logic [18:0] idle;
    idle = e(0, 0, 8'h00, 4'b0000, 0, 1, 1, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    // idle, back-to-back ALU writes, mem priority
    add(0,0,0,8'h00, 0,0,8'h00, 0, idle);
    add(0,0,0,8'h00, 1,1,8'h5A, 0, idle);
    add(0,0,0,8'h00, 1,2,8'hC3, 0, e(1,1,8'h5A,4'b0010,0,0,1,1));
    add(0,0,0,8'h00, 0,0,8'h00, 0, e(1,2,8'hC3,4'b0100,0,0,1,1));
    add(0,1,3,8'h11, 1,2,8'h22, 0, e(0,0,8'h00,4'b0000,0,1,1,0));
    add(0,0,0,8'h00, 1,2,8'h22, 0, e(1,3,8'h11,4'b1000,0,0,1,1));
    add(0,0,0,8'h00, 0,0,8'h00, 0, e(1,2,8'h22,4'b0100,0,0,1,1));
    // r0 discard, stall on empty
    add(0,0,0,8'h00, 1,0,8'h99, 0, idle);
    add(0,0,0,8'h00, 0,0,8'h00, 1, idle);
    // fill under stall, full blocks the fifth, drain
    add(0,0,0,8'h00, 1,1,8'h10, 1, idle);
    add(0,0,0,8'h00, 1,2,8'h11, 1, e(0,1,8'h10,4'b0010,0,0,1,1));
    add(0,0,0,8'h00, 1,3,8'h12, 1, e(0,1,8'h10,4'b0110,0,0,1,1));
    add(0,0,0,8'h00, 1,1,8'h13, 1, e(0,1,8'h10,4'b1110,0,0,1,1));
    add(0,0,0,8'h00, 1,2,8'h14, 1, e(0,1,8'h10,4'b1110,1,0,0,0));
    add(0,0,0,8'h00, 1,2,8'h14, 0, e(1,1,8'h10,4'b1110,1,0,0,0));
    add(0,0,0,8'h00, 0,0,8'h00, 0, e(1,2,8'h11,4'b1110,0,0,1,1));
    add(0,0,0,8'h00, 0,0,8'h00, 0, e(1,3,8'h12,4'b1010,0,0,1,1));
    add(0,0,0,8'h00, 0,0,8'h00, 0, e(1,1,8'h13,4'b0010,0,0,1,1));
    add(0,0,0,8'h00, 0,0,8'h00, 0, idle);
    // two writes to r2 keep pending until the second drains
    add(0,0,0,8'h00, 1,2,8'hAA, 1, idle);
    add(0,0,0,8'h00, 1,2,8'hBB, 1, e(0,2,8'hAA,4'b0100,0,0,1,1));
    add(0,0,0,8'h00, 0,0,8'h00, 0, e(1,2,8'hAA,4'b0100,0,0,1,1));
    add(0,0,0,8'h00, 0,0,8'h00, 0, e(1,2,8'hBB,4'b0100,0,0,1,1));
    add(0,0,0,8'h00, 0,0,8'h00, 0, idle);
    // reset discards three queued entries
    add(0,0,0,8'h00, 1,1,8'h01, 1, idle);
    add(0,0,0,8'h00, 1,2,8'h02, 1, e(0,1,8'h01,4'b0010,0,0,1,1));
    add(0,0,0,8'h00, 1,3,8'h03, 1, e(0,1,8'h01,4'b0110,0,0,1,1));
    add(1,0,0,8'h00, 0,0,8'h00, 0, e(1,1,8'h01,4'b1110,0,0,1,1));
    add(0,0,0,8'h00, 0,0,8'h00, 0, idle);
    add(0,0,0,8'h00, 0,0,8'h00, 0, idle);
    foreach (vecs[i]) begin
      drive(vecs[i].rs, vecs[i].mv, vecs[i].ma, vecs[i].md, vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].ws);
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].exp);
      @(posedge clk); #1;
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    model.delete();
    for (int c = 0; c < 600; c++) begin
      logic [3:0] p;
      logic acc, hw;
      ent_t h, n;
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3, 2'($urandom), 8'($urandom),
            $urandom_range(0, 1) == 1, 2'($urandom), 8'($urandom), $urandom_range(0, 9) < 3);
      p = '0;
      foreach (model[k]) p[model[k].a] = 1'b1;
      h = model.size() != 0 ? model[0] : '0;
      hw = model.size() != 0 && !write_stall;
      @(negedge clk);
      check($sformatf("rand%0d", c),
            e(hw, h.a, h.d, p, model.size() == DEPTH, model.size() == 0,
              model.size() != DEPTH, model.size() != DEPTH && !mem_valid));
      acc = (mem_valid || alu_valid) && model.size() < DEPTH;
      n = mem_valid ? '{mem_address, mem_data} : '{alu_address, alu_data};
      if (reset) model.delete();
      else begin
        if (hw) void'(model.pop_front());
        if (acc && n.a != 2'd0) model.push_back(n);
      end
      @(posedge clk); #1;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
